hv_supply_interlock: RTL and testbench
======================================

Name: hv_supply_interlock

Overview:
- Parametrised interlock and ready-qualification channel for one HV supply stage (G1 grid, anode, or later stages).
- Successor to the fixed-function per-card interlock logic:
  - generic fault-input width
  - counter-based qualification timer with prescaler, replacing fixed-length shift registers
  - latched trip with acknowledge
  - explicit state machine
- Instances chain through upstream_ok/supply_ok so the anode stage is permitted only after G1 reports OK.

Parameters:
N_FAULT, 7, number of active-high fault sources ORed into the alarm
TICK_DIV, 1, clk cycles per timer tick (1 = every cycle); must be >= 1
OK_TICKS, 128, ticks ps_act must be held high, with no fault and u_low clear, before supply_ok
ULOW_TICKS, 4, consecutive ticks of u_low while in OK before a trip
CNT_W, 16, width of the qualification and undervoltage counters; must hold max(OK_TICKS, ULOW_TICKS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
fault_in  in  N_FAULT  fault sources (door, emergency, card position, DC PS, ...), active-high
upstream_ok  in  1  preceding stage OK; tie to 1 for the first stage
ps_act  in  1  supply activation feedback, active-high
u_low  in  1  supply voltage below threshold, active-high
ack  in  1  alarm acknowledge; rising edge is used
on_perm  out  1  permission to switch the supply on
not_alarm  out  1  1 when registered fault OR is clear
supply_ok  out  1  supply qualified and running
not_u_low  out  1  ~(supply_ok & u_low_q)
trip  out  1  latched trip indicator
state  out  2  encoded FSM state, for status readback

Behaviour:
- Input conditioning
  - fault_in, ps_act, u_low and ack are registered once before use (fault_q, ps_q, u_low_q, ack_q); ack_d is a second stage for edge detection.
  - fault_any = |fault_q.
- Tick
  - Prescaler counts 0..TICK_DIV-1; tick is asserted for one cycle at wrap.
  - Prescaler runs freely and is not cleared on state change.
  - Counters advance only on tick.
- FSM states: IDLE=0, RAMP=1, OK=2, TRIP=3. Transition priority, highest first: fault → ps drop → timer.
  - IDLE
    - fault_any → TRIP.
    - else ps_q=1 and upstream_ok=1 → RAMP; qual_cnt is cleared.
  - RAMP
    - fault_any or upstream_ok=0 → TRIP.
    - else ps_q=0 → IDLE.
    - else on tick: qual_cnt+1 if u_low_q=0; qual_cnt cleared to 0 if u_low_q=1.
    - qual_cnt==OK_TICKS → OK.
    - OK_TICKS=0: go to OK on the cycle after entry.
  - OK
    - fault_any or upstream_ok=0 → TRIP.
    - else ps_q=0 → IDLE.
    - else on tick: ulow_cnt+1 if u_low_q=1, else ulow_cnt cleared.
    - ulow_cnt reaching ULOW_TICKS → TRIP.
  - TRIP
    - Held regardless of inputs.
    - Exits to IDLE only on the cycle where ack rises (ack_q=1, ack_d=0) with fault_any=0 and ps_q=0.
    - An ack edge that arrives while a fault or ps_q is still present is discarded; a new edge is required.
- Counters saturate at all-ones and never wrap.
- Both counters clear on any state entry.
- Outputs are registered, updated one cycle after the state register:
  - on_perm = (state!=TRIP) & ~fault_any & upstream_ok
  - not_alarm = ~fault_any
  - supply_ok = (state==OK)
  - trip = (state==TRIP)
- Reset values: state=IDLE, all counters 0, on_perm=0, not_alarm=1, supply_ok=0, not_u_low=1, trip=0.
- Reset asserted mid-RAMP/OK/TRIP forces IDLE immediately. A trip does not survive reset.
- Latency, from the fault_in edge:
  - trip asserts 3 cycles later (input register, state, output register).
  - on_perm drops 2 cycles later.

Optional Feature:
- Macro: HV_INTERLOCK_FIRST_FAULT_EN.
- Enabled:
  - Extra outputs first_fault (N_FAULT bits) and first_fault_vld (1 bit).
  - On entry to TRIP from a fault, fault_q is captured as a snapshot; simultaneous bits are all kept.
  - On a trip from upstream_ok or undervoltage, the snapshot is 0.
  - The snapshot is held until the ack-exit from TRIP or reset, both of which clear it to 0.
  - first_fault_vld = trip & (first_fault!=0).
- Disabled: ports absent; no snapshot logic.

Test Plan:
- Qualification: defaults, ps_act=1, upstream_ok=1, no faults, u_low=0 → supply_ok=1 exactly 128 ticks after RAMP entry, not earlier.
- Mid-ramp fault: fault_in[3]=1 at tick 50 of RAMP → on_perm=0 after 2 cycles, trip=1 after 3; with the macro enabled, first_fault=0x08.
- Ack gating: in TRIP with fault still high, pulse ack → stays TRIP. Clear fault and ps_act, pulse ack again → state=IDLE, trip=0.
- Undervoltage in OK: u_low=1 for 3 ticks then 0 → remains OK. u_low=1 for 4 consecutive ticks → TRIP; not_u_low=0 while in OK with u_low high.
- Chaining: upstream_ok drops while in OK → TRIP. ps_act drop in RAMP with no fault → IDLE, no trip.
- Async reset: assert reset mid-TRIP with TICK_DIV=4 → all outputs at reset values asynchronously; after release, ramp timing restarts from 0.

Source files
------------

// File: rtl/hv_supply_interlock.sv
// Interlock and ready-qualification channel for one HV supply stage.
// Optional first-fault snapshot enabled by HV_INTERLOCK_FIRST_FAULT_EN.
//
//   state | meaning
//   IDLE  | supply off, waiting for ps_act with upstream stage OK
//   RAMP  | supply activated, qualification timer running
//   OK    | supply qualified, undervoltage timer watching u_low
//   TRIP  | latched trip, left only by an ack edge with fault and ps clear
module hv_supply_interlock #(
    parameter int N_FAULT    = 7,
    parameter int TICK_DIV   = 1,
    parameter int OK_TICKS   = 128,
    parameter int ULOW_TICKS = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_FAULT-1:0] fault_in,
    input  logic               upstream_ok,
    input  logic               ps_act,
    input  logic               u_low,
    input  logic               ack,
    output logic               on_perm,
    output logic               not_alarm,
    output logic               supply_ok,
    output logic               not_u_low,
    output logic               trip,
    output logic [1:0]         state
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
    ,
    output logic [N_FAULT-1:0] first_fault,
    output logic               first_fault_vld
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_OK   = 2'd2,
        ST_TRIP = 2'd3
    } state_t;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] OK_CNT   = CNT_W'(OK_TICKS);
    localparam logic [CNT_W-1:0] ULOW_CNT = CNT_W'(ULOW_TICKS);

    logic [N_FAULT-1:0] fault_q;
    logic               ps_q;
    logic               u_low_q;
    logic               ack_q;
    logic               ack_prev_q;

    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]   qual_cnt_q, qual_cnt_d;
    logic [CNT_W-1:0]   ulow_cnt_q, ulow_cnt_d;
    state_t             state_q, state_d;

    logic               on_perm_q, on_perm_d;
    logic               not_alarm_q, not_alarm_d;
    logic               supply_ok_q, supply_ok_d;
    logic               not_u_low_q, not_u_low_d;
    logic               trip_q, trip_d;

    logic               fault_any;
    logic               tick;
    logic               ack_rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fault_any = |fault_q;
    assign tick      = (presc_q == PRE_LAST);
    assign ack_rise  = ack_q & ~ack_prev_q;

    // Prescaler is free running; state changes do not realign it.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        ulow_cnt_d = ulow_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fault_any)
                    state_d = ST_TRIP;
                else if (ps_q && upstream_ok)
                    state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (fault_any || !upstream_ok)
                    state_d = ST_TRIP;
                else if (!ps_q)
                    state_d = ST_IDLE;
                else if (qual_cnt_q == OK_CNT)
                    state_d = ST_OK;
                else if (tick)
                    qual_cnt_d = u_low_q ? '0 : sat_inc(qual_cnt_q);
            end
            ST_OK: begin
                if (fault_any || !upstream_ok)
                    state_d = ST_TRIP;
                else if (!ps_q)
                    state_d = ST_IDLE;
                else if (ulow_cnt_q == ULOW_CNT)
                    state_d = ST_TRIP;
                else if (tick)
                    ulow_cnt_d = u_low_q ? sat_inc(ulow_cnt_q) : '0;
            end
            default: begin
                if (ack_rise && !fault_any && !ps_q)
                    state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            qual_cnt_d = '0;
            ulow_cnt_d = '0;
        end
    end

    // Outputs follow the state register by one cycle.
    always_comb begin
        on_perm_d   = (state_q != ST_TRIP) & ~fault_any & upstream_ok;
        not_alarm_d = ~fault_any;
        supply_ok_d = (state_q == ST_OK);
        not_u_low_d = ~((state_q == ST_OK) & u_low_q);
        trip_d      = (state_q == ST_TRIP);
    end

`ifdef HV_INTERLOCK_FIRST_FAULT_EN
    logic [N_FAULT-1:0] first_fault_q, first_fault_d;

    // Snapshot only on trip entry caused by a fault; other trip causes record zero.
    always_comb begin
        first_fault_d = first_fault_q;
        if (state_q != ST_TRIP && state_d == ST_TRIP)
            first_fault_d = fault_any ? fault_q : '0;
        else if (state_q == ST_TRIP && state_d == ST_IDLE)
            first_fault_d = '0;
    end

    assign first_fault     = first_fault_q;
    assign first_fault_vld = trip_q & (|first_fault_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q       <= '0;
            ps_q          <= 1'b0;
            u_low_q       <= 1'b0;
            ack_q         <= 1'b0;
            ack_prev_q    <= 1'b0;
            presc_q       <= '0;
            qual_cnt_q    <= '0;
            ulow_cnt_q    <= '0;
            state_q       <= ST_IDLE;
            on_perm_q     <= 1'b0;
            not_alarm_q   <= 1'b1;
            supply_ok_q   <= 1'b0;
            not_u_low_q   <= 1'b1;
            trip_q        <= 1'b0;
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
            first_fault_q <= '0;
`endif
        end else begin
            fault_q       <= fault_in;
            ps_q          <= ps_act;
            u_low_q       <= u_low;
            ack_q         <= ack;
            ack_prev_q    <= ack_q;
            presc_q       <= presc_d;
            qual_cnt_q    <= qual_cnt_d;
            ulow_cnt_q    <= ulow_cnt_d;
            state_q       <= state_d;
            on_perm_q     <= on_perm_d;
            not_alarm_q   <= not_alarm_d;
            supply_ok_q   <= supply_ok_d;
            not_u_low_q   <= not_u_low_d;
            trip_q        <= trip_d;
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
            first_fault_q <= first_fault_d;
`endif
        end
    end

    assign on_perm   = on_perm_q;
    assign not_alarm = not_alarm_q;
    assign supply_ok = supply_ok_q;
    assign not_u_low = not_u_low_q;
    assign trip      = trip_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hv_supply_interlock.sv
// Directed bench for hv_supply_interlock: default instance plus a TICK_DIV=4 instance for the reset case.
module tb_hv_supply_interlock;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] fault_in;
    logic       upstream_ok;
    logic       ps_act;
    logic       u_low;
    logic       ack;

    logic       on_perm, not_alarm, supply_ok, not_u_low, trip;
    logic [1:0] state;
    logic       on_perm4, not_alarm4, supply_ok4, not_u_low4, trip4;
    logic [1:0] state4;
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
    logic [6:0] first_fault, first_fault4;
    logic       first_fault_vld, first_fault_vld4;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hv_supply_interlock dut (
        .clk(clk), .reset(reset), .fault_in(fault_in), .upstream_ok(upstream_ok),
        .ps_act(ps_act), .u_low(u_low), .ack(ack),
        .on_perm(on_perm), .not_alarm(not_alarm), .supply_ok(supply_ok),
        .not_u_low(not_u_low), .trip(trip), .state(state)
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        , .first_fault(first_fault), .first_fault_vld(first_fault_vld)
`endif
    );

    hv_supply_interlock #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .fault_in(fault_in), .upstream_ok(upstream_ok),
        .ps_act(ps_act), .u_low(u_low), .ack(ack),
        .on_perm(on_perm4), .not_alarm(not_alarm4), .supply_ok(supply_ok4),
        .not_u_low(not_u_low4), .trip(trip4), .state(state4)
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        , .first_fault(first_fault4), .first_fault_vld(first_fault_vld4)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fault_in = '0; upstream_ok = 1'b1;
        ps_act = 1'b0; u_low = 1'b0; ack = 1'b0;

        // Reset values
        step(3);
        chk("rst_state", state, 0);
        chk("rst_on_perm", on_perm, 0);
        chk("rst_not_alarm", not_alarm, 1);
        chk("rst_supply_ok", supply_ok, 0);
        chk("rst_not_u_low", not_u_low, 1);
        chk("rst_trip", trip, 0);
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        chk("rst_first_fault", first_fault, 0);
`endif
        reset = 1'b0;
        step(2);
        chk("idle_on_perm", on_perm, 1);
        chk("idle_state", state, 0);

        // Qualification: RAMP entry 2 cycles after ps_act, OK after 128 ticks + 1
        ps_act = 1'b1;
        step(2);
        chk("ramp_entry", state, 1);
        step(128);
        chk("ramp_not_early_state", state, 1);
        chk("ramp_not_early_ok", supply_ok, 0);
        step(1);
        chk("ok_state", state, 2);
        chk("ok_out_lag", supply_ok, 0);
        step(1);
        chk("ok_supply_ok", supply_ok, 1);

        // Undervoltage for 3 ticks: stays OK
        u_low = 1'b1;
        step(2);
        chk("ulow_not_u_low", not_u_low, 0);
        step(1);
        u_low = 1'b0;
        step(5);
        chk("ulow3_state", state, 2);
        chk("ulow3_supply_ok", supply_ok, 1);
        chk("ulow3_not_u_low", not_u_low, 1);

        // Undervoltage for 4 ticks: trips
        u_low = 1'b1;
        step(4);
        u_low = 1'b0;
        step(1);
        chk("ulow4_pre_trip", state, 2);
        step(1);
        chk("ulow4_state", state, 3);
        step(1);
        chk("ulow4_trip", trip, 1);
        chk("ulow4_supply_ok", supply_ok, 0);
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        chk("ulow4_first_fault", first_fault, 0);
        chk("ulow4_ff_vld", first_fault_vld, 0);
`endif
        ps_act = 1'b0;
        step(3);
        pulse_ack();
        step(1);
        chk("ulow_ack_state", state, 0);
        step(1);
        chk("ulow_ack_trip", trip, 0);

        // Mid-ramp fault at tick 50
        ps_act = 1'b1;
        step(52);
        chk("fault_pre_state", state, 1);
        fault_in = 7'h08;
        step(1);
        chk("fault_c1_on_perm", on_perm, 1);
        step(1);
        chk("fault_c2_on_perm", on_perm, 0);
        chk("fault_c2_trip", trip, 0);
        chk("fault_c2_state", state, 3);
        step(1);
        chk("fault_c3_trip", trip, 1);
        chk("fault_c3_not_alarm", not_alarm, 0);
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        chk("fault_first_fault", first_fault, 7'h08);
        chk("fault_ff_vld", first_fault_vld, 1);
`endif

        // Ack gating
        pulse_ack();
        step(3);
        chk("ack_with_fault", state, 3);
        fault_in = '0;
        ps_act = 1'b0;
        step(3);
        chk("ack_stale_edge", state, 3);
        pulse_ack();
        step(1);
        chk("ack_exit_state", state, 0);
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        chk("ack_exit_first_fault", first_fault, 0);
`endif
        step(1);
        chk("ack_exit_trip", trip, 0);

        // Chaining: upstream_ok drops in OK
        ps_act = 1'b1;
        step(132);
        chk("chain_ok", supply_ok, 1);
        upstream_ok = 1'b0;
        step(1);
        chk("chain_state", state, 3);
        chk("chain_on_perm", on_perm, 0);
        step(1);
        chk("chain_trip", trip, 1);
        chk("chain_supply_ok", supply_ok, 0);
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        chk("chain_first_fault", first_fault, 0);
`endif
        upstream_ok = 1'b1;
        ps_act = 1'b0;
        step(3);
        pulse_ack();
        step(1);
        chk("chain_ack_state", state, 0);

        // ps_act drop in RAMP returns to IDLE without trip
        ps_act = 1'b1;
        step(12);
        chk("psdrop_ramp", state, 1);
        ps_act = 1'b0;
        step(2);
        chk("psdrop_state", state, 0);
        step(1);
        chk("psdrop_trip", trip, 0);
        chk("psdrop_on_perm", on_perm, 1);

        // Async reset mid-TRIP, TICK_DIV=4 instance
        fault_in = 7'h01;
        step(5);
        chk("div4_trip", trip4, 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_state", state4, 0);
        chk("areset_trip", trip4, 0);
        chk("areset_on_perm", on_perm4, 0);
        chk("areset_not_alarm", not_alarm4, 1);
        chk("areset_supply_ok", supply_ok4, 0);
        chk("areset_not_u_low", not_u_low4, 1);
        chk("areset_main_trip", trip, 0);
`ifdef HV_INTERLOCK_FIRST_FAULT_EN
        chk("areset_first_fault", first_fault4, 0);
`endif
        fault_in = '0;
        ps_act = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
        chk("div4_ramp_entry", state4, 1);
        step(510);
        chk("div4_not_early", state4, 1);
        chk("div4_not_early_ok", supply_ok4, 0);
        step(1);
        chk("div4_ok_state", state4, 2);
        step(1);
        chk("div4_supply_ok", supply_ok4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
